// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch (IF) and load/store (LS).
// LS has priority; a starvation counter forces an IF grant after STARVE_LIMIT LS wins.
module mem_port_arbiter #(
  parameter int AWIDTH       = 32,
  parameter int DWIDTH       = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [AWIDTH-1:0] if_addr_i,
  input  logic              if_flush_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DWIDTH-1:0] if_rdata_o,
  input  logic              ls_req_i,
  input  logic              ls_we_i,
  input  logic [AWIDTH-1:0] ls_addr_i,
  input  logic [DWIDTH-1:0] ls_wdata_i,
  input  logic [1:0]        ls_size_i,
  input  logic              ls_unsigned_i,
  output logic              ls_gnt_o,
  output logic              ls_rvalid_o,
  output logic [DWIDTH-1:0] ls_rdata_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [DWIDTH-1:0] mem_wdata_o,
  output logic              mem_read_en_o,
  output logic              mem_write_en_o,
  output logic [1:0]        mem_size_o,
  output logic              mem_unsigned_o,
  input  logic [DWIDTH-1:0] mem_rdata_i,
  output logic              busy_o
);

  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [2:0] LAT_INIT  = 3'(MEM_LATENCY);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t            state, state_next;
  logic [2:0]        lat_cnt;
  logic [3:0]        starve_cnt;
  logic [AWIDTH-1:0] addr_q;
  logic [DWIDTH-1:0] wdata_q;
  logic [1:0]        size_q;
  logic              we_q;
  logic              unsigned_q;
  logic              owner_ls_q;
  logic              drop_q;
  logic              ls_win;
  logic              if_win;
  logic              last_cycle;

  // Grant gating on rst keeps every output low while reset is held.
  always_comb begin
    ls_win = 1'b0;
    if_win = 1'b0;
    if (state == IDLE && !rst) begin
      ls_win = ls_req_i && !(if_req_i && starve_cnt == STARVE_MAX);
      if_win = if_req_i && !ls_win;
    end
  end

  assign last_cycle = (state == WAIT) && (lat_cnt == 3'd1);

  always_comb begin
    state_next     = state;
    if_gnt_o       = if_win;
    ls_gnt_o       = ls_win;
    if_rvalid_o    = 1'b0;
    if_rdata_o     = '0;
    ls_rvalid_o    = 1'b0;
    ls_rdata_o     = '0;
    mem_addr_o     = '0;
    mem_wdata_o    = '0;
    mem_read_en_o  = 1'b0;
    mem_write_en_o = 1'b0;
    mem_size_o     = 2'b00;
    mem_unsigned_o = 1'b0;
    busy_o         = 1'b0;
    case (state)
      IDLE: begin
        if (if_win || ls_win) state_next = WAIT;
      end
      WAIT: begin
        busy_o         = 1'b1;
        mem_addr_o     = addr_q;
        mem_wdata_o    = wdata_q;
        mem_read_en_o  = !we_q;
        mem_write_en_o = we_q;
        mem_size_o     = size_q;
        mem_unsigned_o = unsigned_q;
        if (last_cycle) begin
          state_next = IDLE;
          if (owner_ls_q) begin
            ls_rvalid_o = 1'b1;
            ls_rdata_o  = we_q ? '0 : mem_rdata_i;
          end else if (!(drop_q || if_flush_i)) begin
            if_rvalid_o = 1'b1;
            if_rdata_o  = mem_rdata_i;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Request latch, latency countdown, starvation count and fetch-drop flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_cnt    <= '0;
      starve_cnt <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= '0;
      we_q       <= 1'b0;
      unsigned_q <= 1'b0;
      owner_ls_q <= 1'b0;
      drop_q     <= 1'b0;
    end else if (ls_win) begin
      addr_q     <= ls_addr_i;
      wdata_q    <= ls_wdata_i;
      size_q     <= ls_size_i;
      we_q       <= ls_we_i;
      unsigned_q <= ls_unsigned_i;
      owner_ls_q <= 1'b1;
      drop_q     <= 1'b0;
      lat_cnt    <= LAT_INIT;
      if (if_req_i && starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + 4'd1;
    end else if (if_win) begin
      addr_q     <= if_addr_i;
      wdata_q    <= '0;
      size_q     <= SIZE_WORD;
      we_q       <= 1'b0;
      unsigned_q <= 1'b1;
      owner_ls_q <= 1'b0;
      drop_q     <= 1'b0;
      lat_cnt    <= LAT_INIT;
      starve_cnt <= '0;
    end else if (state == WAIT) begin
      lat_cnt <= lat_cnt - 3'd1;
      if (last_cycle) begin
        drop_q <= 1'b0;
      end else if (!owner_ls_q && if_flush_i) begin
        drop_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised and directed bench for mem_port_arbiter against a transaction-level model
// that tracks grant cycle, owner and drop state using plain cycle arithmetic.
module tb_mem_port_arbiter;

  localparam int LAT = 3;
  localparam int SL  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req_i = 1'b0, if_flush_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic        if_gnt_o, if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        ls_req_i = 1'b0, ls_we_i = 1'b0, ls_unsigned_i = 1'b0;
  logic [31:0] ls_addr_i = '0, ls_wdata_i = '0;
  logic [1:0]  ls_size_i = '0;
  logic        ls_gnt_o, ls_rvalid_o;
  logic [31:0] ls_rdata_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic        mem_read_en_o, mem_write_en_o, mem_unsigned_o, busy_o;
  logic [1:0]  mem_size_o;

  logic [31:0] tbmem [16];
  assign mem_rdata_i = tbmem[mem_addr_o[5:2]];

  mem_port_arbiter #(.AWIDTH(32), .DWIDTH(32), .MEM_LATENCY(LAT), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
    .if_gnt_o(if_gnt_o), .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_addr_i(ls_addr_i), .ls_wdata_i(ls_wdata_i),
    .ls_size_i(ls_size_i), .ls_unsigned_i(ls_unsigned_i),
    .ls_gnt_o(ls_gnt_o), .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_read_en_o(mem_read_en_o),
    .mem_write_en_o(mem_write_en_o), .mem_size_o(mem_size_o), .mem_unsigned_o(mem_unsigned_o),
    .mem_rdata_i(mem_rdata_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ifr;
    logic [31:0] ifa;
    logic        ifl;
    logic        lsr;
    logic        lswe;
    logic [31:0] lsa;
    logic [31:0] lsw;
    logic [1:0]  lssz;
    logic        lsu;
  } stim_t;

  typedef struct {
    bit          ls;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    bit          uns;
  } txn_t;

  stim_t s;
  txn_t  m_txn;
  bit    m_valid, m_drop;
  int    m_gcyc, m_starve, cyc;
  int    n_cmp, n_err;
  bit    obs_ifg, obs_lsg, obs_ifrv, obs_lsrv, obs_busy, obs_wen;
  logic [31:0] obs_ifrd, obs_lsrd;
  bit    exp_ifg, exp_lsg;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("[TB] FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic modelReset();
    m_valid  = 1'b0;
    m_drop   = 1'b0;
    m_starve = 0;
  endtask

  // One clock cycle: drive at negedge, compare before the rising edge, then advance the model.
  task automatic applyStimulus();
    bit active, last, lswin, ifwin, if_rv, ls_rv;
    logic [31:0] exp_ifrd, exp_lsrd;
    logic [9:0]  exp_ctrl, got_ctrl;
    @(negedge clk);
    if_req_i = s.ifr;  if_addr_i = s.ifa;  if_flush_i = s.ifl;
    ls_req_i = s.lsr;  ls_we_i = s.lswe;   ls_addr_i = s.lsa;
    ls_wdata_i = s.lsw; ls_size_i = s.lssz; ls_unsigned_i = s.lsu;
    #4;
    active = m_valid;
    last   = active && (cyc == m_gcyc + LAT);
    lswin  = !active && s.lsr && !(s.ifr && m_starve == SL);
    ifwin  = !active && s.ifr && !lswin;
    if_rv  = last && !m_txn.ls && !(m_drop || s.ifl);
    ls_rv  = last && m_txn.ls;
    exp_ifrd = if_rv ? tbmem[m_txn.addr[5:2]] : 32'h0;
    exp_lsrd = (ls_rv && !m_txn.we) ? tbmem[m_txn.addr[5:2]] : 32'h0;
    exp_ctrl = {ifwin, lswin, if_rv, ls_rv, active && !m_txn.we, active && m_txn.we, active,
                active ? m_txn.size : 2'b00, active && m_txn.uns};
    got_ctrl = {if_gnt_o, ls_gnt_o, if_rvalid_o, ls_rvalid_o, mem_read_en_o, mem_write_en_o,
                busy_o, mem_size_o, mem_unsigned_o};
    checkOutput("ctrl", 64'(got_ctrl), 64'(exp_ctrl));
    checkOutput("mem_addr", 64'(mem_addr_o), active ? 64'(m_txn.addr) : 64'h0);
    if (!active || m_txn.ls) checkOutput("mem_wdata", 64'(mem_wdata_o), active ? 64'(m_txn.wdata) : 64'h0);
    checkOutput("if_rdata", 64'(if_rdata_o), 64'(exp_ifrd));
    checkOutput("ls_rdata", 64'(ls_rdata_o), 64'(exp_lsrd));
    obs_ifg = if_gnt_o;  obs_lsg = ls_gnt_o;  obs_ifrv = if_rvalid_o;  obs_lsrv = ls_rvalid_o;
    obs_busy = busy_o;   obs_wen = mem_write_en_o;  obs_ifrd = if_rdata_o;  obs_lsrd = ls_rdata_o;
    exp_ifg = ifwin;     exp_lsg = lswin;
    if (active && m_txn.we) tbmem[m_txn.addr[5:2]] = m_txn.wdata;
    if (active && !m_txn.ls && s.ifl) m_drop = 1'b1;
    if (last) begin
      m_valid = 1'b0;
      m_drop  = 1'b0;
    end
    if (lswin) begin
      m_txn.ls = 1'b1;  m_txn.we = s.lswe;  m_txn.addr = s.lsa;
      m_txn.wdata = s.lsw;  m_txn.size = s.lssz;  m_txn.uns = s.lsu;
      if (s.ifr && m_starve < SL) m_starve++;
    end
    if (ifwin) begin
      m_txn.ls = 1'b0;  m_txn.we = 1'b0;  m_txn.addr = s.ifa;
      m_txn.wdata = 32'h0;  m_txn.size = 2'b10;  m_txn.uns = 1'b1;
      m_starve = 0;
    end
    if (lswin || ifwin) begin
      m_valid = 1'b1;
      m_gcyc  = cyc;
      m_drop  = 1'b0;
    end
    cyc++;
  endtask

  task automatic drain();
    s = '0;
    repeat (LAT + 1) applyStimulus();
  endtask

  initial begin
    int first_if, ls_cnt, ls_after, busy_cnt, rv_cnt, regrant, wen_cnt;
    logic [31:0] rd_cap;
    bit pend_if, pend_ls;
    n_cmp = 0; n_err = 0; cyc = 0; m_gcyc = 0;
    modelReset();
    m_txn = '{default: '0};
    for (int i = 0; i < 16; i++) tbmem[i] = $urandom;
    s = '0;

    #2;
    checkOutput("reset_outputs", 64'(|{if_gnt_o, if_rvalid_o, if_rdata_o, ls_gnt_o, ls_rvalid_o,
                ls_rdata_o, mem_addr_o, mem_wdata_o, mem_read_en_o, mem_write_en_o, mem_size_o,
                mem_unsigned_o, busy_o}), 64'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Single fetch
    tbmem[0] = 32'h00500093;
    rd_cap = '0;
    s = '0; s.ifr = 1'b1; s.ifa = 32'h01000000;
    applyStimulus();
    checkOutput("fetch_gnt", 64'(obs_ifg), 64'h1);
    s = '0;
    for (int k = 1; k <= LAT + 1; k++) begin
      applyStimulus();
      if (obs_ifrv) rd_cap = obs_ifrd;
    end
    checkOutput("fetch_rdata", 64'(rd_cap), 64'h00500093);

    // Simultaneous requests; LS withdraws after its grant
    regrant = -1;
    s = '0; s.ifr = 1'b1; s.ifa = 32'h01000004; s.lsr = 1'b1; s.lsa = 32'h01000100; s.lssz = 2'b10;
    for (int k = 0; k <= LAT + 2; k++) begin
      applyStimulus();
      if (k == 0) checkOutput("simul_ls_first", 64'({obs_lsg, obs_ifg}), 64'h2);
      if (obs_lsg) s.lsr = 1'b0;
      if (obs_ifg && regrant < 0) begin
        regrant = k;
        s.ifr = 1'b0;
      end
    end
    checkOutput("simul_if_gnt_cycle", 64'(regrant), 64'(LAT + 1));
    drain();

    // Starvation
    first_if = -1; ls_cnt = 0; ls_after = -1;
    s = '0; s.ifr = 1'b1; s.ifa = 32'h01000008; s.lsr = 1'b1; s.lsa = 32'h0100010C; s.lssz = 2'b01;
    for (int k = 0; k < 6 * (LAT + 1); k++) begin
      applyStimulus();
      if (obs_lsg && first_if < 0) ls_cnt++;
      if (obs_lsg && first_if >= 0 && ls_after < 0) ls_after = k;
      if (obs_ifg && first_if < 0) first_if = k;
    end
    checkOutput("starve_ls_count", 64'(ls_cnt), 64'(SL));
    checkOutput("starve_if_cycle", 64'(first_if), 64'(SL * (LAT + 1)));
    checkOutput("starve_ls_after", 64'(ls_after), 64'((SL + 1) * (LAT + 1)));
    drain();

    // Store then read back
    wen_cnt = 0; rd_cap = '0;
    s = '0; s.lsr = 1'b1; s.lswe = 1'b1; s.lsa = 32'h01000200; s.lsw = 32'hDEADBEEF; s.lssz = 2'b10;
    applyStimulus();
    s = '0;
    for (int k = 1; k <= LAT + 1; k++) begin
      applyStimulus();
      if (obs_wen) wen_cnt++;
      if (obs_lsrv) checkOutput("store_rdata_zero", 64'(obs_lsrd), 64'h0);
    end
    checkOutput("store_wen_cycles", 64'(wen_cnt), 64'(LAT));
    s.lsr = 1'b1; s.lsa = 32'h01000200; s.lssz = 2'b10;
    applyStimulus();
    s = '0;
    for (int k = 1; k <= LAT + 1; k++) begin
      applyStimulus();
      if (obs_lsrv) rd_cap = obs_lsrd;
    end
    checkOutput("store_readback", 64'(rd_cap), 64'hDEADBEEF);

    // Flush of an in-flight fetch; IF keeps requesting
    busy_cnt = 0; rv_cnt = 0; regrant = -1;
    s = '0; s.ifr = 1'b1; s.ifa = 32'h01000010;
    for (int k = 0; k <= LAT + 1; k++) begin
      s.ifl = (k == 2);
      applyStimulus();
      if (k >= 1 && k <= LAT && obs_busy) busy_cnt++;
      if (obs_ifrv) rv_cnt++;
      if (k >= 1 && obs_ifg && regrant < 0) regrant = k;
    end
    checkOutput("flush_busy_cycles", 64'(busy_cnt), 64'(LAT));
    checkOutput("flush_no_rvalid", 64'(rv_cnt), 64'h0);
    checkOutput("flush_regrant_cycle", 64'(regrant), 64'(LAT + 1));
    drain();

    // Async reset in the middle of a transaction
    s = '0; s.ifr = 1'b1; s.ifa = 32'h01000014;
    applyStimulus();
    s = '0;
    applyStimulus();
    @(posedge clk);
    #2;
    if_req_i = 1'b1; ls_req_i = 1'b1; rst = 1'b1;
    #1;
    checkOutput("async_reset_outputs", 64'(|{if_gnt_o, if_rvalid_o, if_rdata_o, ls_gnt_o, ls_rvalid_o,
                ls_rdata_o, mem_addr_o, mem_wdata_o, mem_read_en_o, mem_write_en_o, mem_size_o,
                mem_unsigned_o, busy_o}), 64'h0);
    if_req_i = 1'b0; ls_req_i = 1'b0;
    modelReset();
    @(negedge clk);
    rst = 1'b0;
    s = '0; s.ifr = 1'b1; s.ifa = 32'h01000018;
    applyStimulus();
    checkOutput("post_reset_gnt", 64'(obs_ifg), 64'h1);
    drain();

    // Random traffic
    pend_if = 1'b0; pend_ls = 1'b0; s = '0;
    for (int k = 0; k < 1500; k++) begin
      if (!pend_if && $urandom_range(0, 2) == 0) begin
        pend_if = 1'b1;
        s.ifa = $urandom;
      end else if (pend_if && $urandom_range(0, 15) == 0) begin
        pend_if = 1'b0;
      end
      if (!pend_ls && $urandom_range(0, 2) == 0) begin
        pend_ls = 1'b1;
        s.lswe = 1'($urandom); s.lsa = $urandom; s.lsw = $urandom;
        s.lssz = 2'($urandom); s.lsu = 1'($urandom);
      end else if (pend_ls && $urandom_range(0, 15) == 0) begin
        pend_ls = 1'b0;
      end
      s.ifr = pend_if;
      s.lsr = pend_ls;
      s.ifl = ($urandom_range(0, 9) == 0);
      applyStimulus();
      if (exp_ifg) pend_if = 1'b0;
      if (exp_lsg) pend_ls = 1'b0;
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
